// File: rtl/zigzag_block_reader.sv
// -----------------------------------------------------------------------------
// zigzag_block_reader
//
// Purpose:
//    Captures one packed 8x8 coefficient block for each of Y, Cr and Cb. It then
//    streams the coefficients one per beat in JPEG zig-zag order: the whole Y
//    block first, then Cr, then Cb. Coefficients pass through bit-exact.
//
// Ports:
//    clk         rising-edge clock
//    reset       asynchronous, active-high; clears all state
//    blk_valid   packed block present on Y_in/Cr_in/Cb_in
//    blk_ready   reader can accept a block (only while idle)
//    Y_in        packed Y block, coefficient (r,c) at [(8r+c)*COEF_W +: COEF_W]
//    Cr_in       packed Cr block, same layout
//    Cb_in       packed Cb block, same layout
//    coef_out    current coefficient
//    coef_chan   channel of coef_out: 0=Y, 1=Cr, 2=Cb
//    coef_idx    zig-zag index of coef_out (0 = DC)
//    coef_valid  coef_out/coef_chan/coef_idx/coef_last are valid
//    coef_ready  downstream accepts the current beat
//    coef_last   final beat of the current channel
//    blk_done    one-cycle pulse after the final Cb beat transfers
//
// Build option:
//    ZIGZAG_EOB_TRIM_EN - when defined, each channel stops after its highest
//    nonzero zig-zag coefficient. DC is always sent. When undefined, all 64
//    beats are sent per channel.
// -----------------------------------------------------------------------------
module zigzag_block_reader #(
   parameter int COEF_W = 14,
   parameter int BLK_W  = 64 * COEF_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              blk_valid,
   output logic              blk_ready,
   input  logic [BLK_W-1:0]  Y_in,
   input  logic [BLK_W-1:0]  Cr_in,
   input  logic [BLK_W-1:0]  Cb_in,
   output logic [COEF_W-1:0] coef_out,
   output logic [1:0]        coef_chan,
   output logic [5:0]        coef_idx,
   output logic              coef_valid,
   input  logic              coef_ready,
   output logic              coef_last,
   output logic              blk_done
);

   localparam int IDX_W = $clog2(BLK_W);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_r;
   logic [BLK_W-1:0]    y_r;
   logic [BLK_W-1:0]    cr_r;
   logic [BLK_W-1:0]    cb_r;
   logic [5:0]          last_y_r;
   logic [5:0]          last_cr_r;
   logic [5:0]          last_cb_r;
   logic [1:0]          chan_r;
   logic [5:0]          k_r;

   logic                accept_s;
   logic                xfer_s;
   logic                final_s;
   logic [1:0]          nxt_chan_s;
   logic [5:0]          nxt_k_s;
   logic [BLK_W-1:0]    sel_blk_s;
   logic [5:0]          sel_last_s;
   logic [COEF_W-1:0]   nxt_coef_s;
   logic                nxt_last_s;
   logic [5:0]          lk_y_in_s;
   logic [5:0]          lk_cr_in_s;
   logic [5:0]          lk_cb_in_s;

   // Zig-zag index k -> natural (row-major) index 8r+c.
   function automatic logic [5:0] zz_nat(input logic [5:0] k);
      case (k)
         6'd0:  zz_nat = 6'd0;
         6'd1:  zz_nat = 6'd1;
         6'd2:  zz_nat = 6'd8;
         6'd3:  zz_nat = 6'd16;
         6'd4:  zz_nat = 6'd9;
         6'd5:  zz_nat = 6'd2;
         6'd6:  zz_nat = 6'd3;
         6'd7:  zz_nat = 6'd10;
         6'd8:  zz_nat = 6'd17;
         6'd9:  zz_nat = 6'd24;
         6'd10: zz_nat = 6'd32;
         6'd11: zz_nat = 6'd25;
         6'd12: zz_nat = 6'd18;
         6'd13: zz_nat = 6'd11;
         6'd14: zz_nat = 6'd4;
         6'd15: zz_nat = 6'd5;
         6'd16: zz_nat = 6'd12;
         6'd17: zz_nat = 6'd19;
         6'd18: zz_nat = 6'd26;
         6'd19: zz_nat = 6'd33;
         6'd20: zz_nat = 6'd40;
         6'd21: zz_nat = 6'd48;
         6'd22: zz_nat = 6'd41;
         6'd23: zz_nat = 6'd34;
         6'd24: zz_nat = 6'd27;
         6'd25: zz_nat = 6'd20;
         6'd26: zz_nat = 6'd13;
         6'd27: zz_nat = 6'd6;
         6'd28: zz_nat = 6'd7;
         6'd29: zz_nat = 6'd14;
         6'd30: zz_nat = 6'd21;
         6'd31: zz_nat = 6'd28;
         6'd32: zz_nat = 6'd35;
         6'd33: zz_nat = 6'd42;
         6'd34: zz_nat = 6'd49;
         6'd35: zz_nat = 6'd56;
         6'd36: zz_nat = 6'd57;
         6'd37: zz_nat = 6'd50;
         6'd38: zz_nat = 6'd43;
         6'd39: zz_nat = 6'd36;
         6'd40: zz_nat = 6'd29;
         6'd41: zz_nat = 6'd22;
         6'd42: zz_nat = 6'd15;
         6'd43: zz_nat = 6'd23;
         6'd44: zz_nat = 6'd30;
         6'd45: zz_nat = 6'd37;
         6'd46: zz_nat = 6'd44;
         6'd47: zz_nat = 6'd51;
         6'd48: zz_nat = 6'd58;
         6'd49: zz_nat = 6'd59;
         6'd50: zz_nat = 6'd52;
         6'd51: zz_nat = 6'd45;
         6'd52: zz_nat = 6'd38;
         6'd53: zz_nat = 6'd31;
         6'd54: zz_nat = 6'd39;
         6'd55: zz_nat = 6'd46;
         6'd56: zz_nat = 6'd53;
         6'd57: zz_nat = 6'd60;
         6'd58: zz_nat = 6'd61;
         6'd59: zz_nat = 6'd54;
         6'd60: zz_nat = 6'd47;
         6'd61: zz_nat = 6'd55;
         6'd62: zz_nat = 6'd62;
         6'd63: zz_nat = 6'd63;
         default: zz_nat = 6'd0;
      endcase
   endfunction

   // Coefficient at natural index nat of a packed block.
   function automatic logic [COEF_W-1:0] coef_at(input logic [BLK_W-1:0] blk,
                                                 input logic [5:0]       nat);
      logic [IDX_W-1:0] base;
      base    = IDX_W'(nat) * IDX_W'(COEF_W);
      coef_at = blk[base +: COEF_W];
   endfunction

`ifdef ZIGZAG_EOB_TRIM_EN
   // Highest zig-zag index holding a nonzero coefficient. DC never counts,
   // so an all-zero AC block ends at k=0.
   function automatic logic [5:0] find_last_k(input logic [BLK_W-1:0] blk);
      logic [5:0] lk;
      lk = 6'd0;
      for (int k = 1; k < 64; k++) begin
         if (coef_at(blk, zz_nat(6'(k))) != {COEF_W{1'b0}}) begin
            lk = 6'(k);
         end else begin
            lk = lk;
         end
      end
      return lk;
   endfunction

   assign lk_y_in_s  = find_last_k(Y_in);
   assign lk_cr_in_s = find_last_k(Cr_in);
   assign lk_cb_in_s = find_last_k(Cb_in);
`else
   assign lk_y_in_s  = 6'd63;
   assign lk_cr_in_s = 6'd63;
   assign lk_cb_in_s = 6'd63;
`endif

   assign accept_s = (state_r == IDLE) && blk_ready && blk_valid;
   assign xfer_s   = coef_valid && coef_ready;
   assign final_s  = xfer_s && coef_last && (chan_r == 2'd2);

   // Position of the beat that is presented after the coming edge.
   always_comb begin
      nxt_chan_s = chan_r;
      nxt_k_s    = k_r;
      if (accept_s) begin
         nxt_chan_s = 2'd0;
         nxt_k_s    = 6'd0;
      end else if (xfer_s && !coef_last) begin
         nxt_k_s    = k_r + 6'd1;
      end else if (xfer_s && (chan_r != 2'd2)) begin
         nxt_chan_s = chan_r + 2'd1;
         nxt_k_s    = 6'd0;
      end else begin
         nxt_chan_s = chan_r;
      end
   end

   // Select the block for the next beat. On acceptance the capture registers
   // are not loaded yet, so the first Y beat is taken from the input bus.
   always_comb begin
      sel_blk_s  = {BLK_W{1'b0}};
      sel_last_s = 6'd0;
      if (accept_s) begin
         sel_blk_s  = Y_in;
         sel_last_s = lk_y_in_s;
      end else begin
         case (nxt_chan_s)
            2'd0: begin
               sel_blk_s  = y_r;
               sel_last_s = last_y_r;
            end
            2'd1: begin
               sel_blk_s  = cr_r;
               sel_last_s = last_cr_r;
            end
            2'd2: begin
               sel_blk_s  = cb_r;
               sel_last_s = last_cb_r;
            end
            default: begin
               sel_blk_s  = {BLK_W{1'b0}};
               sel_last_s = 6'd0;
            end
         endcase
      end
      nxt_coef_s = coef_at(sel_blk_s, zz_nat(nxt_k_s));
      nxt_last_s = (nxt_k_s == sel_last_s);
   end

   // Controller FSM with capture registers and registered stream outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         y_r        <= {BLK_W{1'b0}};
         cr_r       <= {BLK_W{1'b0}};
         cb_r       <= {BLK_W{1'b0}};
         last_y_r   <= 6'd0;
         last_cr_r  <= 6'd0;
         last_cb_r  <= 6'd0;
         chan_r     <= 2'd0;
         k_r        <= 6'd0;
         blk_ready  <= 1'b0;
         coef_valid <= 1'b0;
         coef_out   <= {COEF_W{1'b0}};
         coef_chan  <= 2'd0;
         coef_idx   <= 6'd0;
         coef_last  <= 1'b0;
         blk_done   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               blk_done   <= 1'b0;
               coef_valid <= 1'b0;
               if (accept_s) begin
                  y_r        <= Y_in;
                  cr_r       <= Cr_in;
                  cb_r       <= Cb_in;
                  last_y_r   <= lk_y_in_s;
                  last_cr_r  <= lk_cr_in_s;
                  last_cb_r  <= lk_cb_in_s;
                  chan_r     <= nxt_chan_s;
                  k_r        <= nxt_k_s;
                  blk_ready  <= 1'b0;
                  coef_valid <= 1'b1;
                  coef_out   <= nxt_coef_s;
                  coef_chan  <= nxt_chan_s;
                  coef_idx   <= nxt_k_s;
                  coef_last  <= nxt_last_s;
                  state_r    <= SEND;
               end else begin
                  // Also raises ready on the first edge after reset.
                  blk_ready  <= 1'b1;
               end
            end
            SEND: begin
               if (final_s) begin
                  // Ready comes back together with the done pulse, so the
                  // next block can be accepted one cycle later.
                  state_r    <= IDLE;
                  blk_ready  <= 1'b1;
                  blk_done   <= 1'b1;
                  coef_valid <= 1'b0;
                  coef_out   <= {COEF_W{1'b0}};
                  coef_chan  <= 2'd0;
                  coef_idx   <= 6'd0;
                  coef_last  <= 1'b0;
                  chan_r     <= 2'd0;
                  k_r        <= 6'd0;
               end else if (xfer_s) begin
                  blk_done   <= 1'b0;
                  chan_r     <= nxt_chan_s;
                  k_r        <= nxt_k_s;
                  coef_out   <= nxt_coef_s;
                  coef_chan  <= nxt_chan_s;
                  coef_idx   <= nxt_k_s;
                  coef_last  <= nxt_last_s;
               end else begin
                  // Stalled: every output holds its value.
                  blk_done   <= 1'b0;
               end
            end
            default: begin
               state_r    <= IDLE;
               blk_ready  <= 1'b0;
               coef_valid <= 1'b0;
               blk_done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zigzag_block_reader.sv
// -----------------------------------------------------------------------------
// tb_zigzag_block_reader
//
// Directed testbench for zigzag_block_reader. Blocks are built in tb arrays.
// The expected beat stream comes from a hand-written zig-zag table applied to
// those arrays. Each stream is compared beat by beat, including stalled cycles.
// -----------------------------------------------------------------------------
module tb_zigzag_block_reader;

   localparam int COEF_W = 14;
   localparam int BLK_W  = 64 * COEF_W;

   logic              clk;
   logic              reset;
   logic              blk_valid;
   logic              blk_ready;
   logic [BLK_W-1:0]  Y_in;
   logic [BLK_W-1:0]  Cr_in;
   logic [BLK_W-1:0]  Cb_in;
   logic [COEF_W-1:0] coef_out;
   logic [1:0]        coef_chan;
   logic [5:0]        coef_idx;
   logic              coef_valid;
   logic              coef_ready;
   logic              coef_last;
   logic              blk_done;

   int checks = 0;
   int errors = 0;
   int last_cycles = 0;

   int zz_tab [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10,
                       17, 24, 32, 25, 18, 11,  4,  5,
                       12, 19, 26, 33, 40, 48, 41, 34,
                       27, 20, 13,  6,  7, 14, 21, 28,
                       35, 42, 49, 56, 57, 50, 43, 36,
                       29, 22, 15, 23, 30, 37, 44, 51,
                       58, 59, 52, 45, 38, 31, 39, 46,
                       53, 60, 61, 54, 47, 55, 62, 63};

   int          blk [3][64];
   logic [31:0] exp_q [$];

   zigzag_block_reader #(.COEF_W(COEF_W), .BLK_W(BLK_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .Y_in       (Y_in),
      .Cr_in      (Cr_in),
      .Cb_in      (Cb_in),
      .coef_out   (coef_out),
      .coef_chan  (coef_chan),
      .coef_idx   (coef_idx),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .coef_last  (coef_last),
      .blk_done   (blk_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, expv);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] obs_word();
      return {9'd0, coef_chan, coef_idx, coef_last, coef_out};
   endfunction

   task automatic clear_blk();
      for (int ch = 0; ch < 3; ch++)
         for (int i = 0; i < 64; i++) blk[ch][i] = 0;
   endtask

   task automatic fill_ramp(input int oy, input int ocr, input int ocb);
      for (int i = 0; i < 64; i++) begin
         blk[0][i] = i + oy;
         blk[1][i] = i + ocr;
         blk[2][i] = i + ocb;
      end
   endtask

   task automatic load_blk();
      for (int i = 0; i < 64; i++) begin
         Y_in[i*COEF_W +: COEF_W]  = 14'(blk[0][i]);
         Cr_in[i*COEF_W +: COEF_W] = 14'(blk[1][i]);
         Cb_in[i*COEF_W +: COEF_W] = 14'(blk[2][i]);
      end
   endtask

   task automatic accept(input string tag);
      blk_valid = 1'b1;
      step();
      blk_valid = 1'b0;
      check(tag, 32'(coef_valid), 32'd1);
   endtask

   // Expected beats {chan, k, last, coef}, with per-channel final index.
   task automatic build_exp(input int l0, input int l1, input int l2);
      int lk [3];
      lk[0] = l0;
      lk[1] = l1;
      lk[2] = l2;
      exp_q.delete();
      for (int ch = 0; ch < 3; ch++)
         for (int k = 0; k <= lk[ch]; k++)
            exp_q.push_back({9'd0, 2'(ch), 6'(k), (k == lk[ch]), 14'(blk[ch][zz_tab[k]])});
   endtask

   // pat 0: coef_ready always high; pat 1: coef_ready repeats 1,0,0,1.
   task automatic run_stream(input int pat, input int budget);
      int n   = 0;
      int cyc = 0;
      while ((n < exp_q.size()) && (cyc < budget)) begin
         coef_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         check("valid", 32'(coef_valid), 32'd1);
         if (coef_valid) check("beat", obs_word(), exp_q[n]);
         if (coef_valid && coef_ready) n++;
         step();
         cyc++;
      end
      coef_ready = 1'b0;
      last_cycles = cyc;
      check("stream_len", 32'(n), 32'(exp_q.size()));
      check("done_pulse", 32'(blk_done), 32'd1);
      check("ready_back", 32'(blk_ready), 32'd1);
      check("valid_off", 32'(coef_valid), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      blk_valid  = 1'b0;
      coef_ready = 1'b0;
      Y_in       = '0;
      Cr_in      = '0;
      Cb_in      = '0;
      step();
      step();
      check("rst_ready", 32'(blk_ready), 32'd0);
      check("rst_valid", 32'(coef_valid), 32'd0);
      check("rst_out",   32'(coef_out), 32'd0);
      check("rst_chan",  32'(coef_chan), 32'd0);
      check("rst_idx",   32'(coef_idx), 32'd0);
      check("rst_last",  32'(coef_last), 32'd0);
      check("rst_done",  32'(blk_done), 32'd0);
      reset = 1'b0;
      step();
      check("ready_up", 32'(blk_ready), 32'd1);

      // Ramp block, full rate.
      fill_ramp(0, 100, 200);
      load_blk();
      accept("ramp_accept");
      check("accept_ready_low", 32'(blk_ready), 32'd0);
      build_exp(63, 63, 63);
      run_stream(0, 400);
      check("ramp_cycles", 32'(last_cycles), 32'd192);

      // Same block under backpressure, accepted right after blk_done.
      blk_valid = 1'b1;
      step();
      blk_valid = 1'b0;
      check("done_one_cycle", 32'(blk_done), 32'd0);
      check("accept_at_193", 32'(coef_valid), 32'd1);
      run_stream(1, 1000);

      // Extremes: 8191 at (0,0) and -8192 at (7,7).
      clear_blk();
      blk[0][0]  = 8191;
      blk[0][63] = -8192;
      load_blk();
      accept("ext_accept");
      check("ext_dc", 32'(coef_out), 32'h1FFF);
`ifdef ZIGZAG_EOB_TRIM_EN
      build_exp(63, 0, 0);
`else
      build_exp(63, 63, 63);
`endif
      check("ext_k63_model", exp_q[63], {9'd0, 2'd0, 6'd63, 1'b1, 14'h2000});
      run_stream(0, 400);

      // Reset after 70 beats aborts the block.
      fill_ramp(0, 100, 200);
      load_blk();
      accept("abort_accept");
      build_exp(63, 63, 63);
      coef_ready = 1'b1;
      for (int n = 0; n < 70; n++) begin
         check("pre_rst_beat", obs_word(), exp_q[n]);
         step();
      end
      reset = 1'b1;
      #1;
      coef_ready = 1'b0;
      check("abort_valid", 32'(coef_valid), 32'd0);
      check("abort_out",   32'(coef_out), 32'd0);
      check("abort_chan",  32'(coef_chan), 32'd0);
      check("abort_ready", 32'(blk_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_done", 32'(blk_done), 32'd0);
      end
      reset = 1'b0;
      step();
      check("ready_up2", 32'(blk_ready), 32'd1);
      fill_ramp(300, 400, 500);
      load_blk();
      accept("fresh_accept");
      build_exp(63, 63, 63);
      run_stream(0, 400);

      // blk_valid held high across two different blocks.
      fill_ramp(0, 100, 200);
      load_blk();
      build_exp(63, 63, 63);
      blk_valid = 1'b1;
      step();
      check("b2b_accept_a", 32'(coef_valid), 32'd1);
      fill_ramp(1000, 2000, 3000);
      load_blk();
      run_stream(0, 400);
      step();
      blk_valid = 1'b0;
      check("b2b_accept_b", 32'(coef_valid), 32'd1);
      check("b2b_first_b", 32'(coef_out), 32'd1000);
      build_exp(63, 63, 63);
      run_stream(0, 400);

`ifdef ZIGZAG_EOB_TRIM_EN
      // Trimmed end of block: Y 3 beats, Cr 1 beat, Cb 64 beats.
      clear_blk();
      blk[0][8]  = 77;
      blk[2][63] = -5;
      load_blk();
      accept("trim_accept");
      build_exp(2, 0, 63);
      run_stream(0, 400);
      check("trim_cycles", 32'(last_cycles), 32'd68);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
